// File: rtl/fc_argmax.sv
// Argmax stage behind the FC neurons. It captures all class scores once every neuron is done.
// It then walks them one per cycle and pulses valid with the winning index and score.
module fc_argmax #(
  parameter int N_CLASS = 10,
  parameter int DATA_W  = 38,
  parameter int IDX_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CLASS-1:0]          done_fc,
  input  logic [N_CLASS*DATA_W-1:0]   fc_flat,
  output logic [IDX_W-1:0]            class_idx,
  output logic [DATA_W-1:0]           max_val,
  output logic                        valid,
  output logic                        busy
);

  localparam int CNT_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CLASS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] slice   [N_CLASS];
  logic [DATA_W-1:0] cap_reg [N_CLASS];
  logic [DATA_W-1:0] wmax_reg, max_next, cand;
  logic [IDX_W-1:0]  widx_reg, idx_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              all_done, gt, last_step;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLASS; gi++) begin : g_slice
      assign slice[gi] = fc_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign all_done  = &done_fc;
  assign cand      = cap_reg[cnt_reg];
  // Strictly greater keeps the lower index on ties.
  assign gt        = $signed(cand) > $signed(wmax_reg);
  assign max_next  = gt ? cand : wmax_reg;
  assign idx_next  = gt ? IDX_W'(cnt_reg) : widx_reg;
  assign last_step = (cnt_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (all_done) state_next = SCAN;
      SCAN:    if (last_step) state_next = HOLD;
      // Wait for done flags to fall so a held done cannot retrigger.
      HOLD:    if (!all_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASS; k++) cap_reg[k] <= '0;
      wmax_reg  <= '0;
      widx_reg  <= '0;
      cnt_reg   <= '0;
      class_idx <= '0;
      max_val   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (all_done) begin
            for (int k = 0; k < N_CLASS; k++) cap_reg[k] <= slice[k];
            wmax_reg <= slice[0];
            widx_reg <= '0;
            cnt_reg  <= CNT_W'(1);
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          wmax_reg <= max_next;
          widx_reg <= idx_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (last_step) begin
            max_val   <= max_next;
            class_idx <= idx_next;
            valid     <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
